// File: rtl/mult8_seq_ctrl.sv
// 8x8 unsigned multiply sequencer built on one 4x4 multiplier.
// Four nibble passes accumulate into a 16-bit product with start/busy/done.
module mult (
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic [7:0] z
);

  assign z = {4'h0, x} * {4'h0, y};

endmodule

module mult8_seq_ctrl #(
  parameter bit REG_PARTIAL = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        busy,
  output logic        done,
  output logic [15:0] p
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t      state;
  logic [7:0]  opa;
  logic [7:0]  opb;
  logic [1:0]  step;
  logic [15:0] acc;
  logic [15:0] preg;

  logic [3:0]  nx;
  logic [3:0]  ny;
  logic [7:0]  prod;
  logic [15:0] part;
  logic [15:0] addend;
  logic [15:0] sum;

  // step[0] picks the high nibble of a, step[1] the high nibble of b
  always_comb begin
    nx = step[0] ? opa[7:4] : opa[3:0];
    ny = step[1] ? opb[7:4] : opb[3:0];
  end

  mult u_mult (
    .x(nx),
    .y(ny),
    .z(prod)
  );

  always_comb begin
    part = {8'h00, prod};
    unique case (step)
      2'd0:       part = {8'h00, prod};
      2'd1, 2'd2: part = {4'h0, prod, 4'h0};
      default:    part = {prod, 8'h00};
    endcase
  end

  assign addend = REG_PARTIAL ? preg : part;
  assign sum    = acc + addend;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      p     <= 16'h0000;
      opa   <= 8'h00;
      opb   <= 8'h00;
      step  <= 2'd0;
      acc   <= 16'h0000;
      preg  <= 16'h0000;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            opa   <= a;
            opb   <= b;
            acc   <= 16'h0000;
            step  <= 2'd0;
            preg  <= 16'h0000;
            state <= RUN;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        RUN: begin
          step <= step + 2'd1;
          acc  <= sum;
          if (REG_PARTIAL) preg <= part;
          if (step == 2'd3) begin
            if (REG_PARTIAL) begin
              state <= DRAIN;
            end else begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              p     <= sum;
            end
          end
        end
        DRAIN: begin
          // preg holds the last partial; fold it in and publish
          acc   <= sum;
          p     <= sum;
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult8_seq_ctrl.sv
// Scoreboard bench for mult8_seq_ctrl, both REG_PARTIAL settings side by side.
// Shared stimulus; each lane has its own reference model and monitor.
module tb_mult8_seq_ctrl;

  typedef struct {
    logic [15:0] prod;
    int          due;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;

  int errors = 0;
  int checks = 0;
  int acc_cnt [2];
  int pend    [2];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void check(string name, int g, logic [31:0] got,
                                logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s lane%0d: got %0h want %0h", name, g, got, want);
    end
  endfunction

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int LAT = 4 + g;
    logic        busy;
    logic        done;
    logic [15:0] p;
    exp_t        q[$];
    exp_t        e;
    int          cyc = 0;
    int          left = 0;
    logic [15:0] exp_p = 16'h0000;

    mult8_seq_ctrl #(.REG_PARTIAL(g == 1)) dut (
      .clk  (clk),
      .rst  (rst),
      .start(start),
      .a    (a),
      .b    (b),
      .busy (busy),
      .done (done),
      .p    (p)
    );

    // Reference: operation accepted when not busy, result a*b after LAT edges
    initial forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        left = 0;
        q.delete();
      end else if (left > 0) begin
        left--;
      end else if (start) begin
        q.push_back('{prod: {8'h00, a} * {8'h00, b}, due: cyc + LAT});
        left = LAT;
        acc_cnt[g]++;
      end
    end

    initial forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        check("rst_busy", g, 32'(busy), 32'(0));
        check("rst_done", g, 32'(done), 32'(0));
        check("rst_p", g, 32'(p), 32'(0));
        exp_p = 16'h0000;
      end else begin
        check("busy", g, 32'(busy), 32'(left > 0));
        if (done) begin
          if (q.size() == 0) begin
            check("spurious_done", g, 32'(1), 32'(0));
          end else begin
            e = q.pop_front();
            check("done_cycle", g, 32'(cyc), 32'(e.due));
            check("product", g, 32'(p), 32'(e.prod));
            exp_p = e.prod;
          end
        end else begin
          if (q.size() != 0 && q[0].due <= cyc) begin
            check("missing_done", g, 32'(0), 32'(1));
            e = q.pop_front();
          end
          check("p_hold", g, 32'(p), 32'(exp_p));
        end
      end
      pend[g] = q.size();
    end
  end

  task automatic drive(input bit s, input logic [7:0] av,
                       input logic [7:0] bv, input bit r);
    @(negedge clk);
    start = s;
    a     = av;
    b     = bv;
    rst   = r;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 8'($urandom), 8'($urandom), 1'b0);
  endtask

  initial begin
    int n;
    rst   = 1'b1;
    start = 1'b0;
    a     = 8'h00;
    b     = 8'h00;
    acc_cnt[0] = 0;
    acc_cnt[1] = 0;
    pend[0] = 0;
    pend[1] = 0;
    repeat (3) drive(1'b0, 8'h00, 8'h00, 1'b1);

    drive(1'b1, 8'hFF, 8'hFF, 1'b0);
    idle(8);

    drive(1'b1, 8'h12, 8'h34, 1'b0);
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    idle(7);
    drive(1'b1, 8'h00, 8'hAB, 1'b0);
    idle(7);
    drive(1'b1, 8'h01, 8'h80, 1'b0);
    idle(7);

    drive(1'b1, 8'h10, 8'h10, 1'b0);
    repeat (6) drive(1'b1, 8'h0F, 8'h0F, 1'b0);
    idle(8);

    drive(1'b1, 8'h05, 8'h06, 1'b0);
    drive(1'b1, 8'hAA, 8'hBB, 1'b0);
    drive(1'b0, 8'h00, 8'h00, 1'b0);
    drive(1'b1, 8'hCC, 8'hDD, 1'b0);
    idle(8);

    drive(1'b1, 8'h33, 8'h44, 1'b0);
    idle(2);
    drive(1'b0, 8'h00, 8'h00, 1'b1);
    drive(1'b1, 8'h07, 8'h09, 1'b0);
    idle(8);

    n = 0;
    while ((acc_cnt[0] < 520 || acc_cnt[1] < 520) && n < 20000) begin
      drive(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
            $urandom_range(0, 299) == 0);
      n++;
    end
    check("sweep_budget", 0, 32'(n < 20000), 32'(1));
    idle(10);
    check("drained", 0, 32'(pend[0]), 32'(0));
    check("drained", 1, 32'(pend[1]), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mult8_seq_ctrl.md
Name: mult8_seq_ctrl

Overview:
- Sequencer that computes an 8x8 unsigned product by time-multiplexing one instance of the existing 4x4 combinational `mult` over four nibble passes.
- Accumulates the shifted partial products into a 16-bit result.
- Sits between the ALU operand registers and the ALU result mux; provides a start/busy/done handshake for the ALU control FSM.

Parameters:
REG_PARTIAL, 0, 1 = register the `mult` output before accumulation (adds one cycle latency, shortens the critical path); 0 = accumulate `mult` output directly

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only when accepting (IDLE or DONE)
a  input  8  multiplicand; captured on accepted start
b  input  8  multiplier; captured on accepted start
busy  output  1  high while an operation is in progress (RUN, DRAIN)
done  output  1  one-cycle pulse; p is final in this cycle
p  output  16  product; holds last result until the next accepted start

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE; busy=0, done=0, p=0.
  - Internal operand registers, step counter and partial register are cleared.
  - rst overrides every other input, including mid-operation; the aborted result is discarded.
- States:
  - IDLE: busy=0, done=0. start=1 -> capture a,b; acc=0; step=0; go to RUN.
  - RUN: busy=1. Step k selects the nibble pair and shift:
    - k=0: a[3:0]*b[3:0], shift 0
    - k=1: a[7:4]*b[3:0], shift 4
    - k=2: a[3:0]*b[7:4], shift 4
    - k=3: a[7:4]*b[7:4], shift 8
  - RUN with REG_PARTIAL=0: acc += zero-extended partial << shift on each edge; after k=3 go to DONE.
  - RUN with REG_PARTIAL=1: the partial and its shift are registered on each edge. Accumulation happens one edge later. After k=3 go to DRAIN.
  - DRAIN (REG_PARTIAL=1 only): busy=1. Final accumulate, then go to DONE.
  - DONE: busy=0, done=1 for exactly one cycle; p=acc.
    - start=1 in DONE: accepted (back-to-back operation), behaves as in IDLE, goes directly to RUN.
    - Otherwise go to IDLE.
- Latency (start sampled at edge E0):
  - REG_PARTIAL=0: done high in the cycle following E4.
  - REG_PARTIAL=1: done high in the cycle following E5.
  - Throughput: one product per 5 (resp. 6) cycles with back-to-back starts.
- Arithmetic:
  - acc is 16 bits. Maximum 0xFF*0xFF=0xFE01, so no overflow and no carry-out is needed.
  - All partials are zero-extended before shifting.
- Operand stability: a and b are don't-care after capture; changes during RUN/DRAIN must not affect the result.
- start=1 while busy=1 is ignored; no queuing and no error flag.
- p updates only on entry to DONE; it is never exposed with a partial sum.
- Exactly one `mult` instance is used.
- Only states IDLE/RUN/DRAIN/DONE are legal; any illegal encoding returns to IDLE on the next edge.

Test Plan:
- Reset, then a=0xFF, b=0xFF, 1-cycle start -> busy=1 for 4 cycles (REG_PARTIAL=0), then done=1 for 1 cycle with p=0xFE01; p holds 0xFE01 afterwards and done returns to 0.
- a=0x12, b=0x34, start; change a,b to 0x00 the cycle after start -> p=0x03A8. Also a=0x00, b=0xAB -> p=0x0000; a=0x01, b=0x80 -> p=0x0080.
- Back-to-back: start held high continuously with 0x10*0x10, then 0x0F*0x0F -> done pulses 5 cycles apart; p=0x0100, then p=0x00E1.
- start pulsed during busy with different operands -> ignored: exactly one done pulse, and p equals the first operation's product.
- rst=1 two cycles into an operation -> next cycle busy=0, done=0, p=0x0000; a following start with 0x07*0x09 -> p=0x003F.
- REG_PARTIAL=1 rerun of all above -> identical p values, with done exactly one cycle later than with REG_PARTIAL=0. Also run a random 500-pair sweep against a*b with both parameter values.
